seg_scan_mux: RTL

Time-multiplexed scanner for a common-anode multi-digit 7-segment display. Holds a double-buffered hex word, walks the digit index at a fixed refresh rate with a dead-time gap between digits, and presents one 4-bit nibble per slot on `value` to the downstream `BCD_7` decoder together with the matching active-low anode and decimal-point drives. Sits between the datapath that produces display words and `BCD_7`/board pins.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_refresh_prescaler.sv | 33 +++
 rtl/seg_scan_mux.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan multiplexer.
// Polarity constants keep the active-low pin conventions in one place.
package seg_pkg;
  localparam int NUM_DIGITS_DEFAULT = 4;
  localparam int IDX_W = 4;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Wide enough for any practical digit count; users slice to NUM_DIGITS.
  localparam logic [31:0] AN_ALL_OFF = '1;

  typedef logic [IDX_W-1:0] digit_idx_t;
endpackage

// File: rtl/seg_refresh_prescaler.sv
// Slot counter: counts 0..REFRESH_DIV-1 while enabled, holds otherwise.
// Latency: slot_end/on_phase/slot_first are combinational from cnt; no backpressure.
// Backpressure: none; enable low simply freezes the count.
module seg_refresh_prescaler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
)(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic slot_first,
  output logic slot_end,
  output logic on_phase
);
  // One extra bit so ON_LEN never aliases when BLANK_CYCLES is 0.
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam logic [CW-1:0] LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] ON_LEN = CW'(REFRESH_DIV - BLANK_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign slot_first = (cnt == '0);
  assign slot_end   = enable && (cnt == LAST);
  assign on_phase   = (cnt < ON_LEN);
endmodule

// File: rtl/seg_scan_mux.sv
// Common-anode 7-seg scanner with double-buffered word; optional SEG_LEADING_ZERO_BLANK_EN.
// Latency: all outputs registered, one cycle behind the scan state.
// Backpressure: none; load is a strobe, enable low blanks and freezes the scan.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEFAULT,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              value,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);
  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];

  logic slot_first, slot_end, on_phase, frame_end;
  digit_idx_t idx;
  logic [4*NUM_DIGITS-1:0] disp, pend;
  logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
  logic                    pend_v;

  logic [3:0]            cur_val;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] cur_an;
  logic [NUM_DIGITS-1:0] lz;

  seg_refresh_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .slot_first (slot_first),
    .slot_end   (slot_end),
    .on_phase   (on_phase)
  );

  assign frame_end = slot_end && (idx == LAST_IDX);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // lz[k]: digit k and everything more significant is zero; digit 0 never blanks.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (disp[4*k +: 4] == 4'h0);
      lz[k] = (k > 0) && zero_above;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    cur_val = 4'h0;
    cur_dp  = 1'b0;
    cur_an  = ALL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == digit_idx_t'(k)) begin
        cur_val   = disp[4*k +: 4];
        cur_dp    = disp_dp[k] && !lz[k];
        cur_an[k] = lz[k] ? AN_OFF : AN_ON;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      disp        <= '0;
      disp_dp     <= '0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
      value       <= 4'h0;
      an          <= ALL_OFF;
      dp          <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + digit_idx_t'(1);
      end

      // A load on the boundary bypasses pending so it is never overtaken by stale data.
      if (load && frame_end) begin
        disp    <= data_in;
        disp_dp <= dp_in;
        pend_v  <= 1'b0;
      end else if (load) begin
        pend    <= data_in;
        pend_dp <= dp_in;
        pend_v  <= 1'b1;
      end else if (frame_end && pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
        pend_v  <= 1'b0;
      end

      value       <= cur_val;
      an          <= (enable && on_phase) ? cur_an : ALL_OFF;
      dp          <= (enable && on_phase && cur_dp) ? DP_ON : DP_OFF;
      frame_start <= enable && slot_first && (idx == '0);
    end
  end
endmodule
